sdf_stage_ctrl: RTL and testbench



---
 rtl/sdf_stage_ctrl.sv | 132 +++++++++++++
 tb/tb_sdf_stage_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: counts accepted
// samples, drives delay-line shift, butterfly/fill select, twiddle address and frame-end flush.
module sdf_stage_ctrl #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int DW    = 14,
  parameter int TW_AW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic signed [DW-1:0] data_in_r,
  input  logic signed [DW-1:0] data_in_i,
  output logic                 ready_o,
  output logic signed [DW-1:0] data_out_r,
  output logic signed [DW-1:0] data_out_i,
  output logic                 shift_en,
  output logic                 bf_sel,
  output logic                 valid_o,
  output logic                 tw_en,
  output logic [TW_AW-1:0]     tw_addr,
  output logic                 busy
);

  localparam int CW = $clog2(N);
  localparam int SH = $clog2(N / (2 * DEPTH));
  localparam logic [CW-1:0] P_LAST = CW'(2 * DEPTH - 1);
  localparam logic [CW-1:0] D_MASK = CW'(DEPTH - 1);
  localparam logic [CW-1:0] D_BIT  = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    r_fcnt;
  logic             r_first_blk;

  logic             w_accept;
  logic [CW-1:0]    w_cnt;
  logic             w_bf_phase;
  logic             w_blk_end;
  logic             w_first;
  logic             w_start_flush;
  logic             w_flush_step;
  logic [CW-1:0]    w_flush_idx;
  logic [TW_AW-1:0] w_tw_fill;
  logic [TW_AW-1:0] w_tw_flush;

  assign ready_o  = (r_state != S_FLUSH);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = valid_i & ready_o;

  // A sample accepted in IDLE always opens a frame at position 0.
  assign w_cnt      = (r_state == S_IDLE) ? '0 : r_cnt;
  assign w_bf_phase = (w_cnt & D_BIT) != '0;
  assign w_blk_end  = (w_cnt & P_LAST) == P_LAST;
  assign w_first    = (r_state == S_IDLE) | r_first_blk;

  // In RUN, cnt == 0 only right after a frame wrapped; a gap there ends the stream.
  assign w_start_flush = (r_state == S_RUN) & (r_cnt == '0) & ~valid_i;
  assign w_flush_step  = w_start_flush | ((r_state == S_FLUSH) & (r_fcnt != D_MASK));
  assign w_flush_idx   = w_start_flush ? '0 : r_fcnt + CW'(1);

  assign w_tw_fill  = TW_AW'(w_cnt & D_MASK) << SH;
  assign w_tw_flush = TW_AW'(w_flush_idx) << SH;

  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; every register, including the data pass-through, is cleared.
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_fcnt      <= '0;
      r_first_blk <= 1'b0;
      data_out_r  <= '0;
      data_out_i  <= '0;
      shift_en    <= 1'b0;
      bf_sel      <= 1'b0;
      valid_o     <= 1'b0;
      tw_en       <= 1'b0;
      tw_addr     <= '0;
    end else begin
      shift_en <= 1'b0;
      valid_o  <= 1'b0;
      tw_en    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_first_blk <= 1'b1;
          if (w_accept) r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_start_flush) begin
            r_state <= S_FLUSH;
            r_fcnt  <= '0;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == D_MASK) r_state <= S_IDLE;
          else                  r_fcnt  <= w_flush_idx;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept) begin
        r_cnt      <= w_cnt + CW'(1);
        data_out_r <= data_in_r;
        data_out_i <= data_in_i;
        shift_en   <= 1'b1;
        bf_sel     <= w_bf_phase;
        if (w_bf_phase) begin
          valid_o <= 1'b1;
          tw_addr <= '0;
          if (w_blk_end) r_first_blk <= 1'b0;
        end else begin
          // The first block's fill phase only primes the delay line.
          valid_o <= ~w_first;
          tw_en   <= ~w_first;
          tw_addr <= w_tw_fill;
        end
      end

      if (w_flush_step) begin
        shift_en <= 1'b1;
        bf_sel   <= 1'b0;
        valid_o  <= 1'b1;
        tw_en    <= 1'b1;
        tw_addr  <= w_tw_flush;
      end
    end
  end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: a D=8 and a D=16 instance share stimulus and are compared
// each cycle against a frame-level reference model, plus fixed timeline spot checks.
module tb_sdf_stage_ctrl;

  localparam int N     = 32;
  localparam int DW    = 14;
  localparam int TW_AW = 4;
  localparam int VW    = 6 + TW_AW + 2 * DW;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 valid_i = 1'b0;
  logic signed [DW-1:0] din_r = '0;
  logic signed [DW-1:0] din_i = '0;

  logic [1:0]           ready_o, shift_en, bf_sel, valid_o, tw_en, busy;
  logic signed [DW-1:0] dout_r [2];
  logic signed [DW-1:0] dout_i [2];
  logic [TW_AW-1:0]     tw_addr [2];

  int n_vec = 0;
  int n_err = 0;

  // Reference model state, one slot per instance.
  int                   m_mode [2];  // 0 idle, 1 streaming, 2 flushing
  int                   m_pos  [2];
  int                   m_fpos [2];
  bit                   m_first[2];
  bit                   m_wrap [2];
  bit                   e_shift[2], e_bf[2], e_valid[2], e_tw[2];
  int                   e_addr [2];
  logic signed [DW-1:0] e_dr [2];
  logic signed [DW-1:0] e_di [2];

  always #5 clk = ~clk;

  sdf_stage_ctrl #(.N(N), .DEPTH(8), .DW(DW), .TW_AW(TW_AW)) u_dut_d8 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_in_r(din_r), .data_in_i(din_i),
    .ready_o(ready_o[0]), .data_out_r(dout_r[0]), .data_out_i(dout_i[0]),
    .shift_en(shift_en[0]), .bf_sel(bf_sel[0]), .valid_o(valid_o[0]), .tw_en(tw_en[0]),
    .tw_addr(tw_addr[0]), .busy(busy[0])
  );

  sdf_stage_ctrl #(.N(N), .DEPTH(16), .DW(DW), .TW_AW(TW_AW)) u_dut_d16 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .data_in_r(din_r), .data_in_i(din_i),
    .ready_o(ready_o[1]), .data_out_r(dout_r[1]), .data_out_i(dout_i[1]),
    .shift_en(shift_en[1]), .bf_sel(bf_sel[1]), .valid_o(valid_o[1]), .tw_en(tw_en[1]),
    .tw_addr(tw_addr[1]), .busy(busy[1])
  );

  function automatic int dep(int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic logic [VW-1:0] act_vec(int k);
    return {ready_o[k], busy[k], shift_en[k], bf_sel[k], valid_o[k], tw_en[k],
            tw_addr[k] & {TW_AW{tw_en[k]}}, dout_r[k], dout_i[k]};
  endfunction

  function automatic logic [VW-1:0] exp_vec(int k);
    logic [TW_AW-1:0] a;
    a = e_tw[k] ? TW_AW'(e_addr[k]) : TW_AW'(0);
    return {m_mode[k] != 2, m_mode[k] != 0, e_shift[k], e_bf[k], e_valid[k], e_tw[k],
            a, e_dr[k], e_di[k]};
  endfunction

  task automatic model_reset(int k);
    m_mode[k] = 0;  m_pos[k] = 0;  m_fpos[k] = 0;  m_first[k] = 0;  m_wrap[k] = 0;
    e_shift[k] = 0; e_bf[k] = 0; e_valid[k] = 0; e_tw[k] = 0; e_addr[k] = 0;
    e_dr[k] = '0;   e_di[k] = '0;
  endtask

  task automatic model_step(int k, bit v, logic signed [DW-1:0] dr, logic signed [DW-1:0] di);
    int d, stride, p;
    d = dep(k);
    stride = N / (2 * d);
    e_shift[k] = 0; e_valid[k] = 0; e_tw[k] = 0;
    if (m_mode[k] == 0) m_first[k] = 1;
    if (v && m_mode[k] != 2) begin
      p = m_pos[k] % (2 * d);
      e_shift[k] = 1;
      e_bf[k]    = (p >= d);
      e_dr[k]    = dr;
      e_di[k]    = di;
      if (p >= d) begin
        e_valid[k] = 1;
        e_addr[k]  = 0;
        if (p == 2 * d - 1) m_first[k] = 0;
      end else begin
        e_valid[k] = !m_first[k];
        e_tw[k]    = !m_first[k];
        e_addr[k]  = p * stride;
      end
      m_pos[k]  = m_pos[k] + 1;
      m_wrap[k] = 0;
      if (m_pos[k] == N) begin
        m_pos[k]  = 0;
        m_wrap[k] = 1;
      end
      m_mode[k] = 1;
    end else if (m_mode[k] == 1 && m_wrap[k]) begin
      m_wrap[k] = 0;
      m_mode[k] = 2;
      m_fpos[k] = 0;
      e_shift[k] = 1; e_bf[k] = 0; e_valid[k] = 1; e_tw[k] = 1; e_addr[k] = 0;
    end else if (m_mode[k] == 2) begin
      if (m_fpos[k] == d - 1) begin
        m_mode[k] = 0;
      end else begin
        m_fpos[k] = m_fpos[k] + 1;
        e_shift[k] = 1; e_bf[k] = 0; e_valid[k] = 1; e_tw[k] = 1;
        e_addr[k]  = m_fpos[k] * stride;
      end
    end
  endtask

  // Drive one cycle of stimulus, advance the model, and return at the following negedge.
  task automatic apply(bit v, bit r, bit hold);
    rst     = r;
    valid_i = v;
    if (!hold) begin
      din_r = DW'($urandom);
      din_i = DW'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      if (r) model_reset(k);
      else   model_step(k, v, din_r, din_i);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({ready_o[k], busy[k], shift_en[k], bf_sel[k], valid_o[k], tw_en[k], tw_addr[k],
           dout_r[k], dout_i[k]} !== {1'b1, {(VW-1){1'b0}}}) begin
        n_err++;
        $display("FAIL reset d=%0d got=%h want ready=1 rest=0", dep(k), act_vec(k));
      end
    end
  endtask

  task automatic test_continuous();
    apply(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 60; t++) begin
      apply(t <= 32, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL continuous d=%0d t=%0d got=%h exp=%h", dep(k), t, act_vec(k), exp_vec(k));
        end
      end
      if (t <= 8) begin
        n_vec++;
        if ({shift_en[0], valid_o[0]} !== 2'b10) begin
          n_err++;
          $display("FAIL cont_fill t=%0d shift/valid got=%b want=10", t, {shift_en[0], valid_o[0]});
        end
      end
      if (t >= 17 && t <= 24) begin
        n_vec++;
        if ({tw_en[0], tw_addr[0]} !== {1'b1, TW_AW'(2 * (t - 17))}) begin
          n_err++;
          $display("FAIL cont_tw t=%0d got=%b/%0d want=1/%0d", t, tw_en[0], tw_addr[0], 2 * (t - 17));
        end
      end
      if (t >= 33 && t <= 40) begin
        n_vec++;
        if ({valid_o[0], tw_en[0], tw_addr[0]} !== {2'b11, TW_AW'(2 * (t - 33))}) begin
          n_err++;
          $display("FAIL cont_flush t=%0d got=%b%b/%0d want=11/%0d", t, valid_o[0], tw_en[0],
                   tw_addr[0], 2 * (t - 33));
        end
      end
      if (t == 41) begin
        n_vec++;
        if (busy[0] !== 1'b0) begin
          n_err++;
          $display("FAIL cont_idle t=41 busy got=%b want=0", busy[0]);
        end
      end
      if (t >= 17 && t <= 32) begin
        n_vec++;
        if (bf_sel[1] !== 1'b1) begin
          n_err++;
          $display("FAIL d16_bf t=%0d bf_sel got=%b want=1", t, bf_sel[1]);
        end
      end
      if (t >= 33 && t <= 48) begin
        n_vec++;
        if ({tw_en[1], tw_addr[1]} !== {1'b1, TW_AW'(t - 33)}) begin
          n_err++;
          $display("FAIL d16_flush t=%0d got=%b/%0d want=1/%0d", t, tw_en[1], tw_addr[1], t - 33);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    apply(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 100; t++) begin
      apply(t <= 64, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL back_to_back d=%0d t=%0d got=%h exp=%h", dep(k), t, act_vec(k), exp_vec(k));
        end
      end
      if (t >= 33 && t <= 40) begin
        n_vec++;
        if ({ready_o[0], valid_o[0], tw_addr[0]} !== {2'b11, TW_AW'(2 * (t - 33))}) begin
          n_err++;
          $display("FAIL b2b_drain t=%0d got=%b%b/%0d want=11/%0d", t, ready_o[0], valid_o[0],
                   tw_addr[0], 2 * (t - 33));
        end
      end
      if (t == 65) begin
        n_vec++;
        if ({ready_o[0], tw_en[0], tw_addr[0]} !== {2'b01, TW_AW'(0)}) begin
          n_err++;
          $display("FAIL b2b_flush t=65 got=%b%b/%0d want=01/0", ready_o[0], tw_en[0], tw_addr[0]);
        end
      end
    end
  endtask

  task automatic test_stall();
    apply(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 70; t++) begin
      apply(t <= 12 || (t >= 16 && t <= 35), 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL stall d=%0d t=%0d got=%h exp=%h", dep(k), t, act_vec(k), exp_vec(k));
        end
      end
      if (t >= 13 && t <= 15) begin
        n_vec++;
        if ({shift_en, valid_o} !== 4'b0000) begin
          n_err++;
          $display("FAIL stall_gap t=%0d shift/valid got=%b want=0000", t, {shift_en, valid_o});
        end
      end
      if (t == 16) begin
        n_vec++;
        if ({shift_en[0], bf_sel[0], valid_o[0], tw_en[0]} !== 4'b1110) begin
          n_err++;
          $display("FAIL stall_resume t=16 got=%b want=1110",
                   {shift_en[0], bf_sel[0], valid_o[0], tw_en[0]});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    apply(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 21; t++) apply(1'b1, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      n_vec++;
      if ({ready_o[k], busy[k], shift_en[k], bf_sel[k], valid_o[k], tw_en[k], tw_addr[k],
           dout_r[k], dout_i[k]} !== {1'b1, {(VW-1){1'b0}}}) begin
        n_err++;
        $display("FAIL reset_mid d=%0d got=%h want ready=1 rest=0", dep(k), act_vec(k));
      end
    end
    for (int t = 1; t <= 55; t++) begin
      apply(t <= 32, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL reset_mid_frame d=%0d t=%0d got=%h exp=%h", dep(k), t, act_vec(k), exp_vec(k));
        end
      end
      if (t <= 8) begin
        n_vec++;
        if (valid_o[0] !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_fill t=%0d valid_o got=%b want=0", t, valid_o[0]);
        end
      end
    end
  endtask

  task automatic test_flush_valid();
    logic signed [DW-1:0] held;
    held = '0;
    apply(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 70; t++) begin
      apply(t != 33 && t <= 60, 1'b0, t > 34);
      if (t == 34) held = din_r;
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL flush_valid d=%0d t=%0d got=%h exp=%h", dep(k), t, act_vec(k), exp_vec(k));
        end
      end
      if (t >= 34 && t <= 40) begin
        n_vec++;
        if (ready_o[0] !== 1'b0) begin
          n_err++;
          $display("FAIL flush_ready t=%0d ready_o got=%b want=0", t, ready_o[0]);
        end
      end
      if (t == 42) begin
        n_vec++;
        if ({shift_en[0], valid_o[0], dout_r[0]} !== {2'b10, held}) begin
          n_err++;
          $display("FAIL flush_accept t=42 got=%b%b/%0d want=10/%0d", shift_en[0], valid_o[0],
                   dout_r[0], held);
        end
      end
    end
  endtask

  task automatic test_random();
    apply(1'b0, 1'b1, 1'b0);
    for (int t = 1; t <= 800; t++) begin
      apply($urandom_range(0, 3) != 0, $urandom_range(0, 149) == 0, 1'b0);
      for (int k = 0; k < 2; k++) begin
        n_vec++;
        if (act_vec(k) !== exp_vec(k)) begin
          n_err++;
          $display("FAIL random d=%0d t=%0d got=%h exp=%h", dep(k), t, act_vec(k), exp_vec(k));
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_continuous();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_flush_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
